alu_seq: RTL and testbench

//   Parametrised, registered successor to the single-cycle datapath ALU. Keeps the existing 4-bit

---
 rtl/alu_seq.sv | 205 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked EX-stage ALU.
//   Single-cycle ops (and/or/add/xor/srl/sll/sub/slt/sra) complete one cycle after accept.
//   mul (low WIDTH bits of the unsigned product) runs one shift-add step per cycle.
//   divu (restoring quotient) runs one subtract step per cycle.
//   Both iterative ops show out_valid WIDTH+1 cycles after accept.
//   Illegal or disabled opcodes return result=0 with err=1 after one cycle.
//
// Configuration macro: ALU_SEQ_DIV_EN
//   Defined:   opcode 1101 (divu) is implemented; x/0 returns all ones with err=0.
//   Undefined: no divider logic is built and 1101 is treated as illegal.
//
// Parameters:
//   WIDTH  operand/result width; must be a power of two and >= 8.
//   SHW    shift-amount width, derived as $clog2(WIDTH).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   op_a/op_b/alu_ctrl are valid
//   in_ready   unit can accept; high only in IDLE
//   op_a       operand 1, width WIDTH
//   op_b       operand 2, width WIDTH; shifts use op_b[SHW-1:0]
//   alu_ctrl   4-bit operation select
//   out_valid  result valid; held until out_ready
//   out_ready  consumer takes the result
//   result     operation result, width WIDTH
//   zero       result == 0
//   err        illegal or disabled opcode
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       stateQ, stateD;
  logic [SHW-1:0]   cntQ;
  logic [WIDTH-1:0] aQ, bQ, accQ;
  logic [WIDTH-1:0] resultQ;
  logic             errQ;

  // Single-cycle decode of the incoming operation
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] singleRes;
  logic             singleErr;
  logic             isIter;
  logic             isDiv;

  assign shamt = op_b[SHW-1:0];

  always_comb begin
    singleRes = '0;
    singleErr = 1'b0;
    isIter    = 1'b0;
    isDiv     = 1'b0;
    case (alu_ctrl)
      4'b0000: singleRes = op_a & op_b;
      4'b0001: singleRes = op_a | op_b;
      4'b0010: singleRes = op_a + op_b;
      4'b0011: singleRes = op_a ^ op_b;
      4'b0100: singleRes = op_a >> shamt;
      4'b0101: singleRes = op_a << shamt;
      4'b0110: singleRes = op_a - op_b;
      4'b0111: singleRes = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b1000: singleRes = $unsigned($signed(op_a) >>> shamt);
      4'b1100: isIter = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      4'b1101: begin
        isIter = 1'b1;
        isDiv  = 1'b1;
      end
`endif
      default: singleErr = 1'b1;
    endcase
  end

  // One iteration step of the multiply or divide.
  // mul:  accQ accumulates the product, aQ is the multiplicand (shifted left),
  //       bQ is the multiplier (shifted right, LSB selects the add).
  // divu: accQ is the partial remainder, aQ shifts dividend bits out and
  //       quotient bits in, bQ holds the divisor.
  logic [WIDTH-1:0] nextAcc, nextA, nextB, iterRes;
  logic [WIDTH-1:0] mulAcc;

  assign mulAcc = accQ + (bQ[0] ? aQ : '0);

`ifdef ALU_SEQ_DIV_EN
  logic             isDivQ;
  logic [WIDTH:0]   remShift, remDiff;
  logic             divFits;

  assign remShift = {accQ, aQ[WIDTH-1]};
  assign remDiff  = remShift - {1'b0, bQ};
  // A zero divisor always fits, which yields an all-ones quotient
  assign divFits  = ~remDiff[WIDTH];

  always_comb begin
    if (isDivQ) begin
      nextAcc = divFits ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
      nextA   = {aQ[WIDTH-2:0], divFits};
      nextB   = bQ;
      iterRes = nextA;
    end else begin
      nextAcc = mulAcc;
      nextA   = aQ << 1;
      nextB   = bQ >> 1;
      iterRes = nextAcc;
    end
  end
`else
  always_comb begin
    nextAcc = mulAcc;
    nextA   = aQ << 1;
    nextB   = bQ >> 1;
    iterRes = nextAcc;
  end
`endif

  logic lastStep;
  assign lastStep = (cntQ == SHW'(WIDTH - 1));

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (in_valid) stateD = isIter ? BUSY : DONE;
      BUSY:    if (lastStep) stateD = DONE;
      DONE:    if (out_ready) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= IDLE;
      cntQ    <= '0;
      aQ      <= '0;
      bQ      <= '0;
      accQ    <= '0;
      resultQ <= '0;
      errQ    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      isDivQ  <= 1'b0;
`endif
    end else begin
      stateQ <= stateD;
      case (stateQ)
        IDLE: begin
          if (in_valid) begin
            if (isIter) begin
              // Operands are captured here; later input changes are ignored
              aQ   <= op_a;
              bQ   <= op_b;
              accQ <= '0;
              cntQ <= '0;
`ifdef ALU_SEQ_DIV_EN
              isDivQ <= isDiv;
`endif
            end else begin
              resultQ <= singleRes;
              errQ    <= singleErr;
            end
          end
        end
        BUSY: begin
          aQ   <= nextA;
          bQ   <= nextB;
          accQ <= nextAcc;
          cntQ <= cntQ + 1'b1;
          if (lastStep) begin
            resultQ <= iterRes;
            errQ    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // isDiv only matters when the divider is built
  logic unusedIsDiv;
  assign unusedIsDiv = isDiv;

  assign in_ready  = (stateQ == IDLE);
  assign out_valid = (stateQ == DONE);
  assign result    = resultQ;
  assign zero      = (resultQ == '0);
  assign err       = errQ;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [3:0]   alu_ctrl = 4'b0000;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic         err;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .alu_ctrl  (alu_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, keep in_valid high with junk operands while the
  // unit is busy (must be ignored), then check latency, outputs and release.
  task automatic runOp(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int expLat, input logic [W-1:0] expRes,
                       input logic expErr);
    int   lat;
    logic blocked;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    tick();
    op_a     = ~a;
    op_b     = ~b;
    alu_ctrl = 4'b0010;
    lat      = 1;
    blocked  = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready !== 1'b0) blocked = 1'b0;
      tick();
      lat++;
    end
    chk({tag, " lat"}, W'(lat), W'(expLat));
    chk({tag, " result"}, result, expRes);
    chk({tag, " zero"}, W'(zero), W'(expRes == '0));
    chk({tag, " err"}, W'(err), W'(expErr));
    chk({tag, " busy in_ready"}, W'(blocked & ~in_ready), W'(1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " release"}, W'({in_ready, out_valid}), W'(2'b10));
  endtask

  initial begin
    int   lat;
    logic ok;

    // Reset state
    #2;
    chk("rst in_ready", W'(in_ready), W'(1));
    chk("rst out_valid", W'(out_valid), W'(0));
    chk("rst result", result, '0);
    chk("rst zero/err", W'({zero, err}), W'(2'b10));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    runOp("add wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, 1, 32'h0000_0001, 1'b0);
    runOp("sub zero", 4'b0110, 32'h0000_000A, 32'h0000_000A, 1, 32'h0000_0000, 1'b0);
    runOp("srl", 4'b0100, 32'hFFFF_FFFF, 32'h0000_0029, 1, 32'h007F_FFFF, 1'b0);
    runOp("sra", 4'b1000, 32'h8000_0000, 32'h0000_0004, 1, 32'hF800_0000, 1'b0);
    runOp("slt neg", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0001, 1'b0);
    runOp("slt pos", 4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1'b0);
    runOp("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'h00F0_00F0, 1'b0);
    runOp("or", 4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'hFFF0_FFF0, 1'b0);
    runOp("xor", 4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'hFF00_FF00, 1'b0);
    runOp("sll", 4'b0101, 32'h0000_0001, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0);
    runOp("illegal", 4'b1111, 32'h1234_5678, 32'h0000_0001, 1, 32'h0000_0000, 1'b1);
    runOp("mul", 4'b1100, 32'h0000_FFFF, 32'h0001_0001, 33, 32'hFFFF_FFFF, 1'b0);
    runOp("mul small", 4'b1100, 32'h0000_0007, 32'h0000_0006, 33, 32'h0000_002A, 1'b0);
`ifdef ALU_SEQ_DIV_EN
    runOp("divu", 4'b1101, 32'h0000_0064, 32'h0000_0007, 33, 32'h0000_000E, 1'b0);
    runOp("divu by 0", 4'b1101, 32'h0000_0005, 32'h0000_0000, 33, 32'hFFFF_FFFF, 1'b0);
`else
    runOp("divu off", 4'b1101, 32'h0000_0064, 32'h0000_0007, 1, 32'h0000_0000, 1'b1);
    runOp("divu off 0", 4'b1101, 32'h0000_0005, 32'h0000_0000, 1, 32'h0000_0000, 1'b1);
`endif

    // Result held while the consumer stalls for 5 cycles
    alu_ctrl = 4'b0010;
    op_a     = 32'h0000_0003;
    op_b     = 32'h0000_0004;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a     = 32'hDEAD_BEEF;
    ok       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || result !== 32'h0000_0007 || in_ready !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("hold stable", W'(ok), W'(1));
    chk("hold result", result, 32'h0000_0007);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold release", W'({in_ready, out_valid}), W'(2'b10));

    // Reset at BUSY cycle 10 of a mul discards it
    alu_ctrl = 4'b1100;
    op_a     = 32'h0000_FFFF;
    op_b     = 32'h0001_0001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("mid busy", W'({in_ready, out_valid}), W'(2'b00));
    rst_n = 1'b0;
    #1;
    chk("midrst ready/valid", W'({in_ready, out_valid}), W'(2'b10));
    chk("midrst result", result, '0);
    chk("midrst zero/err", W'({zero, err}), W'(2'b10));
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    lat = 0;
    while (lat < 40) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) ok = 1'b0;
      lat++;
    end
    chk("no stale result", W'(ok), W'(1));

    runOp("post rst add", 4'b0010, 32'h0000_0010, 32'h0000_0020, 1, 32'h0000_0030, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
